// File: rtl/alu_dispatch_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_fsm_if
// Description : Command / unit-enable / completion bundle for alu_dispatch_fsm.
//               master drives commands, slave (the dispatcher) answers.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_dispatch_fsm_if #(
   parameter int FUN_WIDTH = 4,
   parameter int NUM_UNITS = 4
);
   localparam int SEL_W = $clog2(NUM_UNITS);

   logic                       cmd_valid;
   logic [FUN_WIDTH-1:0]       cmd_fun;
   logic                       cmd_ready;
   logic [NUM_UNITS-1:0]       unit_en;
   logic [FUN_WIDTH-SEL_W-1:0] op_sel;
   logic                       out_valid;
   logic [SEL_W-1:0]           out_unit;
   logic                       out_err;

   modport master (
      output cmd_valid, cmd_fun,
      input  cmd_ready, unit_en, op_sel, out_valid, out_unit, out_err
   );

   modport slave (
      input  cmd_valid, cmd_fun,
      output cmd_ready, unit_en, op_sel, out_valid, out_unit, out_err
   );
endinterface
`default_nettype wire

// File: rtl/alu_dispatch_fsm.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_fsm
// Description : Accepts one ALU function code at a time, raises the one-hot
//               enable of the addressed execution unit for EXEC_CYCLES cycles,
//               then reports completion (or an illegal unit index) with a
//               single-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatch_fsm #(
   parameter int FUN_WIDTH   = 4,
   parameter int NUM_UNITS   = 4,
   parameter int EXEC_CYCLES = 1
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   alu_dispatch_fsm_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_UNITS);
   localparam int OP_W  = FUN_WIDTH - SEL_W;
   localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_exec = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [NUM_UNITS-1:0] r_unit_en;
   logic [OP_W-1:0]      r_op_sel;
   logic [SEL_W-1:0]     r_unit;
   logic                 r_err;

   logic                 w_ready;
   logic                 w_accept;
   logic [SEL_W-1:0]     w_idx;
   logic                 w_legal;
   logic [NUM_UNITS-1:0] w_onehot;

   // Ready is a pure state decode so cmd_valid never reaches cmd_ready.
   assign w_ready  = (r_state == c_idle);
   assign w_accept = bus.cmd_valid & w_ready;
   assign w_idx    = bus.cmd_fun[FUN_WIDTH-1 -: SEL_W];
   // Only non-power-of-two unit counts can produce an out-of-range index.
   assign w_legal  = (32'(w_idx) < 32'(NUM_UNITS));

   // One-hot decode of the unit index; all-zero for an illegal index.
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         w_onehot[i] = (32'(w_idx) == 32'(i));
      end
   end

   // Dispatch state machine: IDLE -> EXEC (legal) or DONE (illegal) -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_idle;
         r_cnt     <= '0;
         r_unit_en <= '0;
         r_op_sel  <= '0;
         r_unit    <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_accept) begin
                  r_unit <= w_idx;
                  r_err  <= ~w_legal;
                  if (w_legal) begin
                     r_state   <= c_exec;
                     r_unit_en <= w_onehot;
                     r_op_sel  <= bus.cmd_fun[OP_W-1:0];
                     r_cnt     <= c_cnt_load;
                  end else begin
                     r_state <= c_done;
                  end
               end
            end
            c_exec: begin
               if (r_cnt == '0) begin
                  r_unit_en <= '0;
                  r_state   <= c_done;
               end else begin
                  r_cnt <= r_cnt - c_cnt_one;
               end
            end
            c_done: begin
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   assign bus.cmd_ready = w_ready;
   assign bus.unit_en   = r_unit_en;
   assign bus.op_sel    = r_op_sel;
   // Completion fields are masked so they read zero between pulses.
   assign bus.out_valid = (r_state == c_done);
   assign bus.out_unit  = bus.out_valid ? r_unit : '0;
   assign bus.out_err   = bus.out_valid & r_err;
endmodule
`default_nettype wire
